mod_mul_pow2: RTL and testbench

MOD_MUL_POW2 -- requirements
Module: mod_mul_pow2

---
 rtl/ntt_pkg.sv | 14 +
 rtl/mod_dbl.sv | 21 ++
 rtl/mod_mul_pow2.sv | 101 ++++++++++
 tb/tb_mod_mul_pow2.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants: moduli for both parameter sets and the halving constants (q+1)/2.
package ntt_pkg;

    localparam logic [24:0] Q24 = 25'd16515073;
    localparam logic [24:0] Q25 = 25'd33292289;

    localparam logic [24:0] HalfQ24 = 25'd8257537;
    localparam logic [24:0] HalfQ25 = 25'd16646145;

    function automatic logic [24:0] q_of(input logic mod_sel);
        return mod_sel ? Q24 : Q25;
    endfunction

endpackage

// File: rtl/mod_dbl.sv
// One modular doubling step: x' = 2x mod q for x < q, via a single conditional subtract.
module mod_dbl
    import ntt_pkg::*;
(
    input  logic [24:0] x,
    input  logic        mod,
    output logic [24:0] x_dbl
);

    logic [25:0] t;
    logic [25:0] q_ext;
    logic [25:0] diff;

    always_comb begin
        t     = {x, 1'b0};
        q_ext = {1'b0, q_of(mod)};
        diff  = t - q_ext;
        x_dbl = (t >= q_ext) ? diff[24:0] : t[24:0];
    end

endmodule

// File: rtl/mod_mul_pow2.sv
// Sequential din * 2^k mod q: one modular doubling per cycle, result held until taken.
module mod_mul_pow2
    import ntt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [24:0] din,
    input  logic        mod,
    input  logic [3:0]  shift,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [24:0] dout,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [24:0] dout_q, dout_d;
    logic        mod_q, mod_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [24:0] dbl;

    mod_dbl u_mod_dbl (
        .x     (dout_q),
        .mod   (mod_q),
        .x_dbl (dbl)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        mod_d       = mod_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    dout_d     = din;
                    mod_d      = mod;
                    cnt_d      = shift;
                    in_ready_d = 1'b0;
                    if (shift == 4'd0) begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // dout_q is the working value until the last doubling lands
                dout_d = dbl;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            dout_q      <= 25'd0;
            mod_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            mod_q       <= mod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_mod_mul_pow2.sv
// Self-checking bench for mod_mul_pow2: scoreboard on the output handshake plus latency,
// backpressure and reset checks driven from the stimulus task.
module tb_mod_mul_pow2;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] din;
    logic        mod;
    logic [3:0]  shift;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] dout;
    logic        out_valid;
    logic        out_ready;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    logic [24:0] exp_q[$];

    always #5 clk = ~clk;

    mod_mul_pow2 dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .mod       (mod),
        .shift     (shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [24:0] ref_model(input logic [24:0] x, input logic m,
                                               input logic [3:0] k);
        longint unsigned q;
        longint unsigned v;
        q = m ? 64'd16515073 : 64'd33292289;
        v = longint'(x) << k;
        return 25'(v % q);
    endfunction

    // Scoreboard: compare on every completed output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_output", 32'(dout), 32'hffff_ffff);
            end else begin
                check_eq("dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_op(input logic [24:0] x, input logic m, input logic [3:0] k,
                         input logic [24:0] expected, input int hold);
        int          lat;
        int          wait_cnt;
        logic [24:0] held;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        din       = x;
        mod       = m;
        shift     = k;
        in_valid  = 1'b1;
        exp_q.push_back(expected);
        @(posedge clk); #1;
        in_valid = 1'b0;
        din      = 25'($urandom);
        mod      = 1'($urandom);
        shift    = 4'($urandom);
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(k));
        if (hold > 0) begin
            held = dout;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check_eq("hold_dout", 32'(dout), 32'(held));
                check_eq("hold_in_ready", 32'(in_ready), 32'd0);
                check_eq("hold_out_valid", 32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [24:0] x;
        rst       = 1'b1;
        din       = '0;
        mod       = 1'b0;
        shift     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);

        do_op(25'd8257537, 1'b1, 4'd1, 25'd1, 0);
        do_op(25'd33292288, 1'b0, 4'd1, 25'd33292287, 0);
        do_op(25'd16646145, 1'b0, 4'd1, 25'd1, 0);
        do_op(25'd1, 1'b1, 4'd15, 25'd32768, 0);
        do_op(25'd7, 1'b1, 4'd0, 25'd7, 0);
        do_op(25'd8257539, 1'b1, 4'd1, 25'd5, 0);
        do_op(25'd123456, 1'b0, 4'd5, ref_model(25'd123456, 1'b0, 4'd5), 3);

        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) begin
                x = 25'($urandom_range(0, (m == 1) ? 16515072 : 33292288));
                do_op(x, 1'(m), 4'(k), ref_model(x, 1'(m), 4'(k)), (k % 5 == 0) ? 2 : 0);
            end
        end

        // Reset mid-RUN: operation discarded, nothing pushed to the scoreboard
        din      = 25'd999999;
        mod      = 1'b1;
        shift    = 4'd10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("runrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("runrst_dout", 32'(dout), 32'd0);
        check_eq("runrst_in_ready", 32'(in_ready), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        check_eq("runrst_no_output", 32'(out_valid), 32'd0);

        do_op(25'd4242, 1'b0, 4'd10, ref_model(25'd4242, 1'b0, 4'd10), 0);

        repeat (2) @(posedge clk);
        #1;
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
